udp_message_pack: RTL

//  Transmit-side message packer for the UDP message channel: collects outbound message bytes, frames them as one UDP payload,
//  and feeds the UDP TX engine via start/req/done handshake. Sits between message/cfg reply logic and the ethernet TX core, on phy_clk.
//  One packet in flight at a time; bytes are buffered in an internal FIFO so the producer never sees TX req timing.

---
 rtl/udp_message_pack.sv | 185 ++++++++++++++++++
 1 files changed

// File: rtl/udp_message_pack.sv
// udp_message_pack
//   Transmit-side message packer for the UDP message channel. Outbound message bytes are
//   buffered in an internal FIFO, framed as one UDP payload and handed to the UDP TX engine
//   through a start/req/done handshake. One packet is in flight at a time.
//
// Ports
//   phy_clk        : 125 MHz clock
//   rst_n          : asynchronous active-low reset
//   msg_en_i       : byte write strobe, accepted when msg_ready_o = 1
//   msg_data_i     : payload byte
//   msg_last_i     : marks the last byte of a message (qualified by msg_en_i)
//   msg_ready_o    : packer can accept a byte this cycle
//   tx_start_en_o  : one-cycle packet start pulse to the TX core
//   tx_byte_num_o  : payload length, stable from the start pulse until back in ST_IDLE
//   tx_req_i       : TX core byte request, data returned the next cycle
//   tx_data_o      : payload byte, valid one cycle after tx_req_i
//   tx_done_i      : TX core packet-complete pulse
//   tx_busy_o      : high in every state except ST_IDLE / ST_FILL
//   tx_err_o       : one-cycle error pulse (done timeout, underrun, over-request, early done)
//
// Configuration macro
//   UDP_TX_PAD_EN  : pad short payloads to 18 bytes with 0x00 (no underrun error on the pad)

module udp_message_pack #(
    parameter int unsigned DATA_WIDTH     = 8,
    parameter int unsigned BYTE_NUM_WIDTH = 16,
    parameter int unsigned FIFO_DEPTH     = 2048,
    parameter int unsigned MAX_PKT_BYTES  = 1472,
    parameter int unsigned DONE_TIMEOUT   = 125000
) (
    input  logic                      phy_clk,
    input  logic                      rst_n,
    input  logic                      msg_en_i,
    input  logic [DATA_WIDTH-1:0]     msg_data_i,
    input  logic                      msg_last_i,
    output logic                      msg_ready_o,
    output logic                      tx_start_en_o,
    output logic [BYTE_NUM_WIDTH-1:0] tx_byte_num_o,
    input  logic                      tx_req_i,
    output logic [DATA_WIDTH-1:0]     tx_data_o,
    input  logic                      tx_done_i,
    output logic                      tx_busy_o,
    output logic                      tx_err_o
);

    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam int unsigned TW = $clog2(DONE_TIMEOUT + 1);

`ifdef UDP_TX_PAD_EN
    localparam bit PAD_EN = 1'b1;
`else
    localparam bit PAD_EN = 1'b0;
`endif

    localparam logic [BYTE_NUM_WIDTH-1:0] CNT_ONE = 1;
    localparam logic [BYTE_NUM_WIDTH-1:0] MIN_PAD = 18;
    localparam logic [BYTE_NUM_WIDTH-1:0] MAX_CNT = BYTE_NUM_WIDTH'(MAX_PKT_BYTES);
    localparam logic [AW:0]               PTR_ONE = 1;
    localparam logic [TW-1:0]             TO_ONE  = 1;
    localparam logic [TW-1:0]             TO_LAST = TW'(DONE_TIMEOUT - 1);

    typedef enum logic [2:0] {
        ST_IDLE, ST_FILL, ST_START, ST_SEND, ST_WAIT_DONE, ST_FINISH
    } state_t;

    state_t                    r_state, w_state_next;
    logic [DATA_WIDTH-1:0]     r_mem [FIFO_DEPTH];
    logic [AW:0]               r_wr_ptr, r_rd_ptr;
    logic [BYTE_NUM_WIDTH-1:0] r_byte_cnt, r_sent_cnt, r_byte_num;
    logic [TW-1:0]             r_to_cnt;
    logic [DATA_WIDTH-1:0]     r_tx_data;
    logic                      r_tx_err;

    logic                      w_full, w_empty, w_ready, w_wr, w_close;
    logic [BYTE_NUM_WIDTH-1:0] w_cnt_next, w_sent_next, w_byte_num_close;
    logic                      w_pop, w_flush, w_err, w_clear, w_sent_inc;

    assign w_empty = (r_wr_ptr == r_rd_ptr);
    assign w_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) && (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);

    // Gated by rst_n so the producer sees no ready while the block is held in reset.
    assign w_ready    = ((r_state == ST_IDLE) || (r_state == ST_FILL)) && !w_full && rst_n;
    assign w_wr       = msg_en_i && w_ready;
    assign w_cnt_next = r_byte_cnt + CNT_ONE;
    assign w_close    = w_wr && (msg_last_i || (w_cnt_next == MAX_CNT));
    assign w_sent_next = r_sent_cnt + CNT_ONE;
    assign w_byte_num_close = (PAD_EN && (w_cnt_next < MIN_PAD)) ? MIN_PAD : w_cnt_next;

    always_comb begin
        w_state_next = r_state;
        w_pop        = 1'b0;
        w_flush      = 1'b0;
        w_err        = 1'b0;
        w_clear      = 1'b0;
        w_sent_inc   = 1'b0;
        unique case (r_state)
            ST_IDLE: begin
                if (w_wr) w_state_next = w_close ? ST_START : ST_FILL;
            end
            ST_FILL: begin
                if (w_close) w_state_next = ST_START;
            end
            ST_START: w_state_next = ST_SEND;
            ST_SEND: begin
                if (tx_done_i) begin
                    w_flush      = 1'b1;
                    w_err        = 1'b1;
                    w_state_next = ST_FINISH;
                end else if (tx_req_i) begin
                    w_sent_inc = 1'b1;
                    w_pop      = !w_empty;
                    // With padding, an empty FIFO here can only mean the pad region.
                    w_err      = w_empty && !PAD_EN;
                    if (w_sent_next == r_byte_num) w_state_next = ST_WAIT_DONE;
                end
            end
            ST_WAIT_DONE: begin
                if (tx_req_i) w_err = 1'b1;
                if (tx_done_i) begin
                    w_state_next = ST_FINISH;
                end else if (r_to_cnt == TO_LAST) begin
                    w_flush      = 1'b1;
                    w_err        = 1'b1;
                    w_clear      = 1'b1;
                    w_state_next = ST_IDLE;
                end
            end
            ST_FINISH: begin
                w_flush      = 1'b1;
                w_clear      = 1'b1;
                w_state_next = ST_IDLE;
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    // Payload RAM: no reset, pointers define validity.
    always_ff @(posedge phy_clk) begin
        if (w_wr) r_mem[r_wr_ptr[AW-1:0]] <= msg_data_i;
    end

    always_ff @(posedge phy_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_byte_cnt <= '0;
            r_sent_cnt <= '0;
            r_byte_num <= '0;
            r_to_cnt   <= '0;
            r_tx_data  <= '0;
            r_tx_err   <= 1'b0;
        end else begin
            r_state  <= w_state_next;
            r_tx_err <= w_err;

            if (w_wr) r_wr_ptr <= r_wr_ptr + PTR_ONE;

            if (w_flush)    r_rd_ptr <= r_wr_ptr;
            else if (w_pop) r_rd_ptr <= r_rd_ptr + PTR_ONE;

            r_tx_data <= w_pop ? r_mem[r_rd_ptr[AW-1:0]] : '0;

            if (w_clear)   r_byte_cnt <= '0;
            else if (w_wr) r_byte_cnt <= w_cnt_next;

            if (w_clear)      r_byte_num <= '0;
            else if (w_close) r_byte_num <= w_byte_num_close;

            if (w_clear)         r_sent_cnt <= '0;
            else if (w_sent_inc) r_sent_cnt <= w_sent_next;

            if (r_state == ST_WAIT_DONE) r_to_cnt <= r_to_cnt + TO_ONE;
            else                         r_to_cnt <= '0;
        end
    end

    assign msg_ready_o   = w_ready;
    assign tx_start_en_o = (r_state == ST_START);
    assign tx_byte_num_o = r_byte_num;
    assign tx_data_o     = r_tx_data;
    assign tx_busy_o     = (r_state != ST_IDLE) && (r_state != ST_FILL);
    assign tx_err_o      = r_tx_err;

endmodule
